// File: rtl/n64_pif_bus_master.sv
// n64_pif_bus_master
// RCP-side initiator for the RCP<->PIF serial link. Sends a start bit and an
// 11-bit command {op, addr} and then waits for the PIF ack. After the ack it
// either receives or transmits 1 or 16 32-bit words, MSB first.
//
// Ports:
//   clk, reset_l               system clock, async active-low reset
//   cmd_valid/cmd_ready        host command handshake (cmd_op, cmd_addr)
//   wr_data/wr_pop             show-ahead write word, pop pulse on consume
//   rd_data/rd_valid           received word and its 1-clk strobe
//   done, err_timeout          completion / ack-timeout pulses
//   busy                       transaction in progress
//   pif_clk, rsp_out, pif_in   serial clock, RCP->PIF line, PIF->RCP line
module n64_pif_bus_master #(
  parameter int CLK_DIV     = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [8:0]  cmd_addr,
  input  logic [31:0] wr_data,
  output logic        wr_pop,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err_timeout,
  output logic        busy,
  output logic        pif_clk,
  output logic        rsp_out,
  input  logic        pif_in
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_CMD      = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_RD_DATA  = 3'd4,
    S_WR_START = 3'd5,
    S_WR_DATA  = 3'd6,
    S_WR_END   = 3'd7
  } state_t;

  state_t          state_r, state_nx;
  logic [DW-1:0]   div_cnt_r;
  logic            pif_clk_r;
  logic            sync1_r, sync2_r;
  logic            is_wr_r, is_wr_nx;
  logic [31:0]     sh_r, sh_nx;
  logic [4:0]      bit_idx_r, bit_idx_nx;
  logic [4:0]      words_r, words_nx;
  logic [AW-1:0]   ack_cnt_r, ack_cnt_nx;
  logic            rsp_r, rsp_nx;
  logic [31:0]     rd_data_r, rd_data_nx;
  logic            rd_valid_r, rd_valid_nx;
  logic            wr_pop_r, wr_pop_nx;
  logic            done_r, done_nx;
  logic            err_r, err_nx;
  logic            cmd_ready_r, cmd_ready_nx;
  logic            busy_r;

  logic accept_s, wrap_s, rise_s, fall_s, last_word_s;

  assign accept_s    = cmd_valid & cmd_ready_r;
  assign wrap_s      = (div_cnt_r == DW'(CLK_DIV - 1)) && (state_r != S_IDLE);
  assign rise_s      = wrap_s & ~pif_clk_r;
  assign fall_s      = wrap_s & pif_clk_r;
  assign last_word_s = (words_r == 5'd1);

  // Serial clock divider; held at zero whenever the machine is (or is about to be) idle.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      div_cnt_r <= '0;
      pif_clk_r <= 1'b0;
    end else if (state_nx == S_IDLE) begin
      div_cnt_r <= '0;
      pif_clk_r <= 1'b0;
    end else if (div_cnt_r == DW'(CLK_DIV - 1)) begin
      div_cnt_r <= '0;
      pif_clk_r <= ~pif_clk_r;
    end else begin
      div_cnt_r <= div_cnt_r + DW'(1);
    end
  end

  // Two-flop synchroniser for the PIF->RCP line (idle high).
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= pif_in;
      sync2_r <= sync1_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic: line-driving states advance on rise ticks, sampling states on fall ticks.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE:     if (accept_s) state_nx = S_START; else state_nx = S_IDLE;
      S_START:    if (rise_s) state_nx = S_CMD; else state_nx = S_START;
      // Index 11 is the extra rise tick that returns the line high before the ack window.
      S_CMD:      if (rise_s && bit_idx_r == 5'd11) state_nx = S_WAIT_ACK; else state_nx = S_CMD;
      S_WAIT_ACK: begin
        if (fall_s && !sync2_r) begin
          if (is_wr_r) state_nx = S_WR_START; else state_nx = S_RD_DATA;
        end else if (fall_s && ack_cnt_r == AW'(ACK_TIMEOUT - 1)) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_WAIT_ACK;
        end
      end
      S_RD_DATA:  if (fall_s && bit_idx_r == 5'd31 && last_word_s) state_nx = S_IDLE; else state_nx = S_RD_DATA;
      S_WR_START: if (rise_s) state_nx = S_WR_DATA; else state_nx = S_WR_START;
      S_WR_DATA:  if (rise_s && bit_idx_r == 5'd31 && last_word_s) state_nx = S_WR_END; else state_nx = S_WR_DATA;
      S_WR_END:   if (rise_s) state_nx = S_IDLE; else state_nx = S_WR_END;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Output and datapath next values; the shift register carries the command, then data words.
  always_comb begin
    is_wr_nx    = is_wr_r;
    sh_nx       = sh_r;
    bit_idx_nx  = bit_idx_r;
    words_nx    = words_r;
    ack_cnt_nx  = ack_cnt_r;
    rsp_nx      = rsp_r;
    rd_data_nx  = rd_data_r;
    rd_valid_nx = 1'b0;
    wr_pop_nx   = 1'b0;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    case (state_r)
      S_IDLE: begin
        rsp_nx = 1'b1;
        if (accept_s) begin
          is_wr_nx   = cmd_op[1];
          sh_nx      = {cmd_op, cmd_addr, 21'd0};
          words_nx   = cmd_op[0] ? 5'd16 : 5'd1;
          bit_idx_nx = 5'd0;
        end else begin
          bit_idx_nx = bit_idx_r;
        end
      end
      S_START: begin
        if (rise_s) rsp_nx = 1'b0; else rsp_nx = rsp_r;
      end
      S_CMD: begin
        if (rise_s && bit_idx_r == 5'd11) begin
          rsp_nx     = 1'b1;
          ack_cnt_nx = '0;
        end else if (rise_s) begin
          rsp_nx     = sh_r[31];
          sh_nx      = {sh_r[30:0], 1'b0};
          bit_idx_nx = bit_idx_r + 5'd1;
        end else begin
          rsp_nx = rsp_r;
        end
      end
      S_WAIT_ACK: begin
        if (fall_s && !sync2_r) begin
          bit_idx_nx = 5'd0;
        end else if (fall_s && ack_cnt_r == AW'(ACK_TIMEOUT - 1)) begin
          err_nx = 1'b1;
        end else if (fall_s) begin
          ack_cnt_nx = ack_cnt_r + AW'(1);
        end else begin
          ack_cnt_nx = ack_cnt_r;
        end
      end
      S_RD_DATA: begin
        if (fall_s) begin
          sh_nx = {sh_r[30:0], sync2_r};
          if (bit_idx_r == 5'd31) begin
            rd_data_nx  = {sh_r[30:0], sync2_r};
            rd_valid_nx = 1'b1;
            bit_idx_nx  = 5'd0;
            if (last_word_s) done_nx = 1'b1; else words_nx = words_r - 5'd1;
          end else begin
            bit_idx_nx = bit_idx_r + 5'd1;
          end
        end else begin
          sh_nx = sh_r;
        end
      end
      S_WR_START: begin
        if (rise_s) begin
          rsp_nx     = 1'b0;
          sh_nx      = wr_data;
          wr_pop_nx  = 1'b1;
          bit_idx_nx = 5'd0;
        end else begin
          rsp_nx = rsp_r;
        end
      end
      S_WR_DATA: begin
        if (rise_s) begin
          rsp_nx = sh_r[31];
          sh_nx  = {sh_r[30:0], 1'b0};
          if (bit_idx_r == 5'd31) begin
            bit_idx_nx = 5'd0;
            // Reload directly behind the outgoing LSB so words run back to back.
            if (!last_word_s) begin
              sh_nx     = wr_data;
              wr_pop_nx = 1'b1;
              words_nx  = words_r - 5'd1;
            end else begin
              words_nx = words_r;
            end
          end else begin
            bit_idx_nx = bit_idx_r + 5'd1;
          end
        end else begin
          rsp_nx = rsp_r;
        end
      end
      S_WR_END: begin
        if (rise_s) begin
          rsp_nx  = 1'b1;
          done_nx = 1'b1;
        end else begin
          rsp_nx = rsp_r;
        end
      end
      default: begin
        rsp_nx = 1'b1;
      end
    endcase
    // Ready only after a full idle clock, so it trails done/err_timeout by one clk.
    cmd_ready_nx = (state_r == S_IDLE) && (state_nx == S_IDLE);
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      is_wr_r     <= 1'b0;
      sh_r        <= 32'd0;
      bit_idx_r   <= 5'd0;
      words_r     <= 5'd0;
      ack_cnt_r   <= '0;
      rsp_r       <= 1'b1;
      rd_data_r   <= 32'd0;
      rd_valid_r  <= 1'b0;
      wr_pop_r    <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      is_wr_r     <= is_wr_nx;
      sh_r        <= sh_nx;
      bit_idx_r   <= bit_idx_nx;
      words_r     <= words_nx;
      ack_cnt_r   <= ack_cnt_nx;
      rsp_r       <= rsp_nx;
      rd_data_r   <= rd_data_nx;
      rd_valid_r  <= rd_valid_nx;
      wr_pop_r    <= wr_pop_nx;
      done_r      <= done_nx;
      err_r       <= err_nx;
      cmd_ready_r <= cmd_ready_nx;
      busy_r      <= ~cmd_ready_nx;
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign busy        = busy_r;
  assign pif_clk     = pif_clk_r;
  assign rsp_out     = rsp_r;
  assign rd_data     = rd_data_r;
  assign rd_valid    = rd_valid_r;
  assign wr_pop      = wr_pop_r;
  assign done        = done_r;
  assign err_timeout = err_r;

endmodule

// File: doc/n64_pif_bus_master.md
Name: n64_pif_bus_master

Overview:
- RCP-side initiator for the RCP<->PIF serial link; the master end of the link the PIF responder decodes.
- Generates the serial clock and drives the request line. Serialises a start bit and an 11-bit command of {op[1:0], addr[8:0]}, waits for the PIF ack, then either receives or transmits 1 or 16 32-bit words.
- Used by the bench and by test/bring-up builds where the FPGA stands in for the RCP.
- Host side uses a valid/ready command port, a show-ahead write-word port and a read-word strobe.

Parameters:
CLK_DIV, 4, clk cycles per half serial-clock period (>=2)
ACK_TIMEOUT, 64, serial-clock periods to wait for PIF ack before abort

Ports:
clk  in  1  system clock
reset_l  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high when idle; command accepted on cmd_valid&cmd_ready
cmd_op  in  2  0=read 4B, 1=read 64B, 2=write 4B, 3=write 64B
cmd_addr  in  9  PIF word address
wr_data  in  32  current write word (show-ahead, held until wr_pop)
wr_pop  out  1  1-clk pulse: wr_data consumed, present next word
rd_data  out  32  received word, MSB first on the line
rd_valid  out  1  1-clk pulse per received word
done  out  1  1-clk pulse at successful completion
err_timeout  out  1  1-clk pulse when ack not seen in ACK_TIMEOUT
busy  out  1  transaction in progress
pif_clk  out  1  serial clock to PIF
rsp_out  out  1  RCP->PIF line, idle high
pif_in  in  1  PIF->RCP line, idle high

Behaviour:
- Reset values: cmd_ready=1, busy=0, pif_clk=0, rsp_out=1, rd_data=0. All pulses (wr_pop, rd_valid, done, err_timeout) are 0.
- Reset mid-transaction aborts immediately to these values. No done or err is emitted.
- Clocking:
  - Divider counts 0..CLK_DIV-1 and toggles pif_clk at the wrap. It free-runs while busy and is held low while idle.
  - Rise tick: clk cycle in which pif_clk goes 0->1. rsp_out changes only on rise ticks.
  - Fall tick: pif_clk 1->0. pif_in is sampled only on fall ticks, through a 2-flop synchroniser clocked on clk. The sample used is the synchronised value at the fall tick.
- Accept: on cmd_valid&cmd_ready, latch op/addr. busy=1 and cmd_ready=0 from the next clk. Word count = 1 (op 0/2) or 16 (op 1/3).
- States:
  - IDLE: rsp_out=1.
  - START: rsp_out=0 for one serial bit.
  - CMD: 11 bits, op[1] first, then addr[8] down to addr[0]. One bit per rise tick.
  - WAIT_ACK: rsp_out=1. Count fall ticks. pif_in==0 -> ack.
    - Read ops go to RD_DATA.
    - Write ops go to WR_START.
    - Count reaching ACK_TIMEOUT -> pulse err_timeout, go to IDLE.
  - RD_DATA: shift pif_in MSB first on each fall tick. After each 32nd bit, update rd_data and pulse rd_valid. After the last word, pulse done and go to IDLE.
  - WR_START: one rise tick with rsp_out=0 (write start bit). The word shift register loads wr_data in the same clk and wr_pop pulses.
  - WR_DATA: 32 bits per word, MSB first, on rise ticks.
    - At each word boundary with words remaining: reload from wr_data and pulse wr_pop. No gap bit between words.
    - After the last bit plus one idle-high rise tick: pulse done, go to IDLE.
- Total wr_pop per write = word count. Total rd_valid per read = word count.
- pif_in low during CMD is ignored; ack is recognised only in WAIT_ACK.
- cmd_valid while busy is ignored (not queued).
- cmd_ready returns high the clk after done or err_timeout.

Test Plan:
- Read 4B, op=0, addr=0x1F0; PIF model acks on 3rd fall tick and returns 0xDEADBEEF -> rsp_out shows 0 then 00_111110000; one rd_valid with rd_data=0xDEADBEEF; done; line returns high.
- Read 64B, op=1, addr=0x000; model returns words 0..15 = 0x0000_0000+i -> 16 rd_valid pulses, values in order, 512 bits, single done.
- Write 4B, op=2, addr=0x1FF, wr_data=0xA5A5_0F0F -> after ack: one low start bit then 32 bits matching; one wr_pop; model memory[0x1FF]=0xA5A50F0F.
- Write 64B, op=3, show-ahead FIFO of 16 words -> 16 wr_pop pulses, no gap bits, model stores all 16 in order.
- No ack, ACK_TIMEOUT=8 -> err_timeout after 8 fall ticks in WAIT_ACK; no done; cmd_ready=1 next clk.
- reset_l low mid RD_DATA, plus cmd_valid held high while busy -> outputs take reset values asynchronously; the second command is not started until idle.
